// File: rtl/ex_hazard_sequencer_pkg.sv
// Shared definitions for the EX-stage hazard and multi-cycle sequencer.
package ex_hazard_sequencer_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } seq_state_t;

  localparam logic [4:0] ZERO_REG           = 5'd0;
  localparam int         MDU_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/ex_hazard_sequencer_if.sv
// Pipeline-side signals seen by the hazard sequencer; master drives pipeline status, slave drives controls.
interface ex_hazard_sequencer_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_dest;
  logic             ex_mdu_op;
  logic             mem_branch;
  logic             mem_zero;

  logic             pc_write;
  logic             pc_src;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mdu_busy;
  logic             mdu_done;
  logic             mdu_abort;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest, ex_mdu_op, mem_branch, mem_zero,
    input  pc_write, pc_src, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_flush,
           mdu_busy, mdu_done, mdu_abort, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest, ex_mdu_op, mem_branch, mem_zero,
    output pc_write, pc_src, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_flush,
           mdu_busy, mdu_done, mdu_abort, stall_cycles
  );

endinterface

// File: rtl/ex_hazard_sequencer_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the instruction in ID.
module hazard_detect
  import ex_hazard_sequencer_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  output logic       lu
);

  // Writes to the zero register never create a real dependency.
  assign lu = ex_mem_read && (ex_dest != ZERO_REG) &&
              ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

endmodule

// File: rtl/ex_hazard_sequencer.sv
// Hazard/MDU sequencer: drives front-end enables and flushes, and counts stall cycles.
module ex_hazard_sequencer
  import ex_hazard_sequencer_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_hazard_sequencer_if.slave bus
);

  localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);

  seq_state_t       state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [CNT_W-1:0] stall_q;
  logic             lu;
  logic             br_taken;

  logic pc_write, pc_src, ifid_write, ifid_flush, idex_hold, idex_flush, exmem_flush;
  logic mdu_busy, mdu_done, mdu_abort;

  hazard_detect u_hazard_detect (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_dest     (bus.ex_dest),
    .lu          (lu)
  );

  assign br_taken = bus.mem_branch && bus.mem_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= 4'd0;
      stall_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Priority: reset, taken branch, MDU occupancy, load-use, free run.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    mdu_abort   = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (br_taken) begin
      pc_src      = 1'b1;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      if ((state == BUSY) || bus.ex_mdu_op) begin
        mdu_abort = 1'b1;
        state_n   = RUN;
        cnt_n     = 4'd0;
      end
    end else if (state == BUSY) begin
      mdu_busy = 1'b1;
      if (cnt == 4'd0) begin
        // Final cycle: release holds and ignore ex_mdu_op so the same op does not restart.
        mdu_done = 1'b1;
        state_n  = RUN;
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_hold   = 1'b1;
        exmem_flush = 1'b1;
        cnt_n       = cnt - 4'd1;
      end
    end else if (bus.ex_mdu_op) begin
      mdu_busy    = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_hold   = 1'b1;
      exmem_flush = 1'b1;
      state_n     = BUSY;
      cnt_n       = MDU_LOAD;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_src       = pc_src;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_hold    = idex_hold;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.mdu_busy     = mdu_busy;
  assign bus.mdu_done     = mdu_done;
  assign bus.mdu_abort    = mdu_abort;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_ex_hazard_sequencer;

  localparam int MDU_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: remaining MDU occupancy cycles and the stall count.
  int m_left = 0;
  int m_cnt  = 0;
  bit m_cnt_valid = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  ex_hazard_sequencer #(
    .MDU_CYCLES (MDU_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit uses_rt,
                               input bit mr, input logic [4:0] dest, input bit mdu, input bit br, input bit zero);
    rst            = r;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rt = uses_rt;
    bus.ex_mem_read = mr;
    bus.ex_dest    = dest;
    bus.ex_mdu_op  = mdu;
    bus.mem_branch = br;
    bus.mem_zero   = zero;
  endtask

  // Control vector order: pc_write pc_src ifid_write ifid_flush idex_hold idex_flush exmem_flush mdu_busy mdu_done mdu_abort
  function automatic logic [9:0] model_ctrl(input bit r, input bit br, input bit mdu, input bit lu,
                                            input int left, output int left_n);
    left_n = left;
    if (r) begin
      left_n = 0;
      return 10'b0001011000;
    end else if (br) begin
      left_n = 0;
      return {9'b110101100, (left > 0) || mdu};
    end else if (left == 1) begin
      left_n = 0;
      return 10'b1010000110;
    end else if (left > 1 || mdu) begin
      left_n = (left > 1) ? left - 1 : MDU_CYCLES - 1;
      return 10'b0000101100;
    end else if (lu) begin
      return 10'b0000010000;
    end
    return 10'b1010000000;
  endfunction

  task automatic run_cycle(input string tag, input bit r, input logic [4:0] rs, input logic [4:0] rt,
                           input bit uses_rt, input bit mr, input logic [4:0] dest, input bit mdu,
                           input bit br, input bit zero);
    logic [9:0] exp_ctrl;
    logic [9:0] obs_ctrl;
    int         left_n;
    bit         lu;
    @(negedge clk);
    applyStimulus(r, rs, rt, uses_rt, mr, dest, mdu, br, zero);
    #1;
    lu = mr && (dest != 0) && ((dest == rs) || (uses_rt && (dest == rt)));
    exp_ctrl = model_ctrl(r, br && zero, mdu, lu, m_left, left_n);
    obs_ctrl = {bus.pc_write, bus.pc_src, bus.ifid_write, bus.ifid_flush, bus.idex_hold,
                bus.idex_flush, bus.exmem_flush, bus.mdu_busy, bus.mdu_done, bus.mdu_abort};
    checkOutput({tag, "_ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
    if (m_cnt_valid) checkOutput({tag, "_stall"}, 32'(bus.stall_cycles), 32'(m_cnt));
    if (r) begin
      m_left = 0;
      m_cnt = 0;
      m_cnt_valid = 1'b1;
    end else begin
      m_left = left_n;
      if (!exp_ctrl[9] && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic idle(input string tag);
    run_cycle(tag, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    run_cycle("reset0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_pc_write", 32'(bus.pc_write), 32'd0);
    checkOutput("reset_flushes", 32'({bus.ifid_flush, bus.idex_flush, bus.exmem_flush}), 32'd7);
    run_cycle("reset1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle("after_reset");
    checkOutput("reset_stall_zero", 32'(bus.stall_cycles), 32'd0);

    // Load-use on rs, then a zero-register destination that must not stall.
    run_cycle("lu", 1'b0, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
    idle("lu_after");
    checkOutput("lu_stall_count", 32'(bus.stall_cycles), 32'd1);
    run_cycle("lu_rt", 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    run_cycle("lu_rt_unused", 1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    run_cycle("lu_zero", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_zero_pc_write", 32'(bus.pc_write), 32'd1);
    idle("lu_zero_after");
    checkOutput("lu_zero_stall_count", 32'(bus.stall_cycles), 32'd2);

    // MDU op occupies EX for four cycles, then a back-to-back op.
    for (int i = 0; i < MDU_CYCLES; i++) begin
      run_cycle("mdu", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      if (i == MDU_CYCLES - 1) checkOutput("mdu_done", 32'({bus.mdu_done, bus.pc_write}), 32'd3);
    end
    run_cycle("mdu_b2b", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("mdu_b2b_hold", 32'(bus.idex_hold), 32'd1);
    checkOutput("mdu_stall_count", 32'(bus.stall_cycles), 32'd5);

    // Taken branch kills the running MDU op.
    run_cycle("br_busy", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("br_busy_abort", 32'({bus.mdu_abort, bus.pc_src}), 32'd3);
    idle("br_after");
    checkOutput("br_after_run", 32'(bus.pc_write), 32'd1);

    // Branch beats load-use: no stall added.
    run_cycle("br_lu", 1'b0, 5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1);
    idle("br_lu_after");
    checkOutput("br_lu_stall_count", 32'(bus.stall_cycles), 32'd6);
    run_cycle("br_not_taken", 1'b0, 5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);

    // Reset during BUSY aborts silently.
    run_cycle("rst_busy_go", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    run_cycle("rst_busy", 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_busy_abort", 32'(bus.mdu_abort), 32'd0);
    idle("rst_busy_after");
    checkOutput("rst_busy_stall_zero", 32'(bus.stall_cycles), 32'd0);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) run_cycle("sat", 1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    idle("sat_after");
    checkOutput("sat_stall_15", 32'(bus.stall_cycles), 32'd15);
    run_cycle("sat_more", 1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    idle("sat_more_after");
    checkOutput("sat_stall_hold", 32'(bus.stall_cycles), 32'd15);

    // Random traffic on a small register set so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      run_cycle("rand", ($urandom_range(0, 39) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
